// File: rtl/pixel_lut_pkg.sv
// pixel_lut_pkg: shared state encoding, default widths and the pixel-valid test for pixel_lut_ram
package pixel_lut_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 12;
  localparam logic [DEF_DATA_W-1:0] DEF_INVALID_VAL = '0;
  function automatic logic pix_is_valid(input logic [63:0] data, input logic [63:0] invalid);
    return data != invalid;
  endfunction
endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core: single-clock simple dual-port array, one write port, registered read port (ports: clk, we/wa/wd write, ra read address, q read data)
module sdp_ram_core #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    q <= mem[ra];
  end
endmodule

// File: rtl/pixel_lut_ram.sv
// pixel_lut_ram: pixel/LUT memory with clear FSM, read handshake, RD_LAT 1|2, write-first forwarding (ports: clk, rst, clr_req/clr_busy, wr_req/wr_add/wr_data/wr_ready, rd_req/rd_add/rd_ready, rd_valid/rd_data/rd_pix_valid)
module pixel_lut_ram import pixel_lut_pkg::*; #(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int                DATA_W       = DEF_DATA_W,
  parameter int                RD_LAT       = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = '0,
  parameter logic [DATA_W-1:0] INVALID_VAL  = DATA_W'(DEF_INVALID_VAL),
  parameter bit                CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_add,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_pix_valid
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_cnt, wa;
  logic [DATA_W-1:0] wd, core_q, fd1, d1;
  logic we, v1, f1, ready;
  assign ready = state == IDLE;
  assign clr_busy = state == CLEAR;
  assign wr_ready = ready;
  assign rd_ready = ready;
  always_comb begin
    state_nx = ready ? (clr_req ? CLEAR : IDLE) : (&clr_cnt ? IDLE : CLEAR);
    we = !rst && (clr_busy || wr_req);
    wa = clr_busy ? clr_cnt : wr_add;
    wd = clr_busy ? CLEAR_VAL : wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RST ? CLEAR : IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      clr_cnt <= clr_busy ? clr_cnt + ADDR_W'(1) : '0;
    end
  end
  sdp_ram_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_core (
    .clk(clk), .we(we), .wa(wa), .wd(wd), .ra(rd_add), .q(core_q)
  );
  // the array reads old data on a same-address write, so the write word is captured alongside
  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else v1 <= rd_req && ready;
    f1 <= wr_req && wr_add == rd_add;
    fd1 <= wr_data;
  end
  assign d1 = f1 ? fd1 : core_q;
  if (RD_LAT == 1) begin : g_lat1
    logic [DATA_W-1:0] held;
    always_ff @(posedge clk) begin
      if (rst) held <= '0;
      else if (v1) held <= d1;
    end
    assign rd_valid = v1;
    assign rd_data = v1 ? d1 : held;
  end else if (RD_LAT == 2) begin : g_lat2
    logic v2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end
    assign rd_valid = v2;
    assign rd_data = d2;
  end else begin : g_bad_lat
    $error("pixel_lut_ram: RD_LAT must be 1 or 2");
  end
  assign rd_pix_valid = rd_valid && pix_is_valid(64'(rd_data), 64'(INVALID_VAL));
endmodule

// File: tb/tb_pixel_lut_ram.sv
// tb_pixel_lut_ram: randomized and directed bench comparing RD_LAT=1 and RD_LAT=2 instances against a queue-based model
module tb_pixel_lut_ram;
  logic clk = 1'b0, rst = 1'b1, clr_req = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic [3:0] wr_add = '0, rd_add = '0;
  logic [11:0] wr_data = '0;
  logic busy1, busy2, wrdy1, wrdy2, rrdy1, rrdy2, rv1, rv2, pv1, pv2;
  logic [11:0] rd1, rd2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  pixel_lut_ram #(.ADDR_W(4), .DATA_W(12), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy1),
    .wr_req(wr_req), .wr_add(wr_add), .wr_data(wr_data), .wr_ready(wrdy1),
    .rd_req(rd_req), .rd_add(rd_add), .rd_ready(rrdy1),
    .rd_valid(rv1), .rd_data(rd1), .rd_pix_valid(pv1));
  pixel_lut_ram #(.ADDR_W(4), .DATA_W(12), .RD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy2),
    .wr_req(wr_req), .wr_add(wr_add), .wr_data(wr_data), .wr_ready(wrdy2),
    .rd_req(rd_req), .rd_add(rd_add), .rd_ready(rrdy2),
    .rd_valid(rv2), .rd_data(rd2), .rd_pix_valid(pv2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {int due; logic [11:0] d;} ent_t;
  ent_t q1[$], q2[$];
  logic [11:0] mem [16];
  logic [11:0] ed [2];
  bit ev [2];
  int busy_left = 0, cyc = 0;
  bit started = 0;

  // model: a pending clear is a count of remaining sweep cycles; reads are (due cycle, word) queue entries
  always @(posedge clk) begin
    ent_t e;
    cyc++;
    if (rst) begin
      started = 1;
      busy_left = 16;
      q1.delete();
      q2.delete();
      ev = '{0, 0};
      ed = '{12'h0, 12'h0};
    end else begin
      if (busy_left > 0) begin
        mem[16 - busy_left] = 12'h000;
        busy_left--;
      end else begin
        if (rd_req) begin
          e.d = (wr_req && wr_add == rd_add) ? wr_data : mem[rd_add];
          e.due = cyc;
          q1.push_back(e);
          e.due = cyc + 1;
          q2.push_back(e);
        end
        if (wr_req) mem[wr_add] = wr_data;
        if (clr_req) busy_left = 16;
      end
      ev[0] = 0;
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); ev[0] = 1; ed[0] = e.d; end
      ev[1] = 0;
      if (q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); ev[1] = 1; ed[1] = e.d; end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy1", busy1, busy_left != 0);
      chk("busy2", busy2, busy_left != 0);
      chk("ready1", {wrdy1, rrdy1}, {2{busy_left == 0}});
      chk("ready2", {wrdy2, rrdy2}, {2{busy_left == 0}});
      chk("rd_valid1", rv1, ev[0]);
      chk("rd_data1", rd1, ed[0]);
      chk("pix_valid1", pv1, ev[0] && ed[0] != 0);
      chk("rd_valid2", rv2, ev[1]);
      chk("rd_data2", rd2, ed[1]);
      chk("pix_valid2", pv2, ev[1] && ed[1] != 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    clr_req = 0; wr_req = 0; rd_req = 0;
  endtask

  task automatic sweep_len(input string name);
    int n;
    n = busy1;
    repeat (20) begin tick(); n += busy1; end
    chk(name, n, 16);
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;
    chk("lit_rst_valid", {rv1, rv2, pv1, pv2}, 4'b0000);
    chk("lit_rst_data", {rd1, rd2}, 24'h0);
    sweep_len("lit_sweep_after_rst");
    for (int i = 0; i < 16; i++) begin rd_req = 1; rd_add = 4'(i); tick(); end
    idle(); repeat (3) tick();
    wr_req = 1; wr_add = 3; wr_data = 12'h00A; tick();
    idle(); rd_req = 1; rd_add = 3; tick();
    idle();
    chk("lit_rd3_lat1", {rv1, pv1, rd1}, {2'b11, 12'h00A});
    chk("lit_rd3_lat2_early", rv2, 0);
    tick();
    chk("lit_rd3_lat2", {rv2, pv2, rd2}, {2'b11, 12'h00A});
    chk("lit_rd3_hold1", {rv1, pv1, rd1}, {2'b00, 12'h00A});
    wr_req = 1; wr_add = 5; wr_data = 12'h123; rd_req = 1; rd_add = 5; tick();
    chk("lit_fwd_lat1", rd1, 12'h123);
    wr_add = 6; wr_data = 12'h456; tick();
    chk("lit_old_word_lat1", rd1, 12'h123);
    rd_req = 0; wr_add = 5; wr_data = 12'h999; tick();
    chk("lit_old_word_lat2", {rv2, rd2}, {1'b1, 12'h123});
    idle(); tick();
    wr_req = 1; wr_add = 2; wr_data = 12'h777; tick();
    idle(); clr_req = 1; tick();
    clr_req = 0; wr_req = 1; wr_add = 2; wr_data = 12'hBBB; rd_req = 1; rd_add = 2;
    repeat (16) tick();
    idle(); rd_req = 1; rd_add = 2; tick();
    idle();
    chk("lit_cleared2", {rv1, pv1, rd1}, {2'b10, 12'h000});
    repeat (2) tick();
    rd_req = 1; rd_add = 5; clr_req = 1; tick();
    idle(); rst = 1; tick();
    rst = 0;
    chk("lit_rst_discard", {rv1, rv2}, 2'b00);
    repeat (7) tick();
    rst = 1; tick();
    rst = 0;
    sweep_len("lit_sweep_after_midrst");
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      clr_req = $urandom_range(0, 99) == 0;
      wr_req = 1'($urandom_range(0, 1));
      rd_req = 1'($urandom_range(0, 1));
      wr_add = 4'($urandom_range(0, 15));
      rd_add = $urandom_range(0, 3) == 0 ? wr_add : 4'($urandom_range(0, 15));
      wr_data = $urandom_range(0, 3) == 0 ? 12'h000 : 12'($urandom);
      tick();
    end
    rst = 0; idle(); repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
